// File: rtl/card_pile_engine.sv
`default_nettype none
// ============================================================================
// card_pile_engine : one solitaire pile with rule-checked load/push/pop/flip
// Revision 1.0
// ============================================================================
module card_pile_engine #(
  parameter  int DEPTH       = 19,
  parameter  int MAX_RUN     = 13,
  parameter  int MODE        = 0,
  parameter  int AUTO_REVEAL = 1,
  localparam int CW          = 7,
  localparam int NW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load_valid,
  input  logic [DEPTH*CW-1:0]   i_load_pile,
  input  logic [NW-1:0]         i_load_count,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  input  logic [1:0]            i_op_code,
  input  logic [NW-1:0]         i_op_count,
  input  logic [MAX_RUN*CW-1:0] i_push_cards,
  output logic [MAX_RUN*CW-1:0] o_pop_cards,
  output logic                  o_done,
  output logic                  o_ok,
  output logic                  o_revealed,
  output logic [DEPTH*CW-1:0]   o_pile,
  output logic [NW-1:0]         o_count,
  output logic [CW-1:0]         o_top_card,
  output logic [NW-1:0]         o_hidden_count
);

  localparam logic [NW-1:0] c_one = 1;
  localparam logic [1:0] c_op_push = 2'b01;
  localparam logic [1:0] c_op_pop  = 2'b10;
  localparam logic [1:0] c_op_flip = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_XFER   = 3'd2,
    S_REVEAL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DEPTH*CW-1:0]   r_pile;
  logic [NW-1:0]         r_count;
  logic [1:0]            r_code;
  logic [NW-1:0]         r_cnt;
  logic [MAX_RUN*CW-1:0] r_run;
  logic [MAX_RUN*CW-1:0] r_pop;
  logic [NW-1:0]         r_idx;
  logic                  r_done;
  logic                  r_ok;
  logic                  r_rev;

  logic [CW-1:0]         w_top;
  logic                  w_below_vis;
  logic [NW-1:0]         w_hidden;
  logic [DEPTH*CW-1:0]   w_load_masked;
  logic                  w_legal;
  logic                  w_run_ok;
  logic [CW-1:0]         w_card;
  logic [CW-1:0]         w_prev;
  logic                  w_last;
  logic                  w_auto;

  // Top card, visibility of the card under it, and hidden-card tally.
  always_comb begin
    w_top       = '0;
    w_below_vis = 1'b1;
    w_hidden    = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j < int'(r_count)) begin
        if (!r_pile[j*CW]) w_hidden = w_hidden + c_one;
        if (j == int'(r_count) - 1) w_top = r_pile[j*CW +: CW];
        if (j == int'(r_count) - 2) w_below_vis = r_pile[j*CW];
      end
    end
  end

  always_comb begin
    w_load_masked = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j < int'(i_load_count)) w_load_masked[j*CW +: CW] = i_load_pile[j*CW +: CW];
    end
  end

  // Legality of the latched operation against the current pile.
  always_comb begin
    w_legal  = 1'b0;
    w_card   = '0;
    w_prev   = w_top;
    w_run_ok = (r_cnt != '0) && (int'(r_cnt) <= MAX_RUN);
    case (r_code)
      c_op_push: begin
        w_legal = w_run_ok && (int'(r_count) + int'(r_cnt) <= DEPTH);
        if (MODE == 1 && r_cnt != c_one) w_legal = 1'b0;
        for (int i = 0; i < MAX_RUN; i++) begin
          if (i < int'(r_cnt)) begin
            w_card = r_run[i*CW +: CW];
            if (MODE != 2 && (!w_card[0] || w_card[6:3] == 4'd0)) w_legal = 1'b0;
            if (MODE == 0) begin
              if (i == 0 && r_count == '0) begin
                if (w_card[6:3] != 4'd13) w_legal = 1'b0;
              end else if (({1'b0, w_card[6:3]} + 5'd1 != {1'b0, w_prev[6:3]}) ||
                           (w_card[1] == w_prev[1])) begin
                w_legal = 1'b0;
              end
            end else if (MODE == 1) begin
              if (r_count == '0) begin
                if (w_card[6:3] != 4'd1) w_legal = 1'b0;
              end else if ((w_card[2:1] != w_prev[2:1]) ||
                           (w_card[6:3] != w_prev[6:3] + 4'd1)) begin
                w_legal = 1'b0;
              end
            end
            w_prev = w_card;
          end
        end
      end
      c_op_pop: begin
        w_legal = w_run_ok && (r_cnt <= r_count);
        for (int j = 0; j < DEPTH; j++) begin
          if (MODE != 2 && j >= int'(r_count) - int'(r_cnt) && j < int'(r_count) &&
              !r_pile[j*CW]) begin
            w_legal = 1'b0;
          end
        end
      end
      c_op_flip: w_legal = (r_count != '0) && !w_top[0];
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_last = (r_idx + c_one == r_cnt);
  // During the final POP beat r_count still includes the card leaving.
  assign w_auto = (AUTO_REVEAL != 0) && (r_count > c_one) && !w_below_vis;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_op_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_op_ready = 1'b1;
        if (i_load_valid)    w_next = S_DONE;
        else if (i_op_valid) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (!w_legal)                w_next = S_DONE;
        else if (r_code == c_op_flip) w_next = S_REVEAL;
        else                          w_next = S_XFER;
      end
      S_XFER: begin
        if (w_last) w_next = (r_code == c_op_pop && w_auto) ? S_REVEAL : S_DONE;
      end
      S_REVEAL: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pile  <= '0;
      r_count <= '0;
      r_code  <= '0;
      r_cnt   <= '0;
      r_run   <= '0;
      r_pop   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_rev   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_load_valid) begin
            r_rev <= 1'b0;
            if (int'(i_load_count) <= DEPTH) begin
              r_pile  <= w_load_masked;
              r_count <= i_load_count;
              r_ok    <= 1'b1;
            end else begin
              r_ok <= 1'b0;
            end
          end else if (i_op_valid) begin
            r_code <= i_op_code;
            r_cnt  <= i_op_count;
            r_run  <= i_push_cards;
          end
        end
        S_CHECK: begin
          r_idx <= '0;
          r_rev <= 1'b0;
          r_ok  <= w_legal;
          if (w_legal && r_code == c_op_pop) r_pop <= '0;
        end
        S_XFER: begin
          r_idx <= r_idx + c_one;
          if (r_code == c_op_push) begin
            r_pile[int'(r_count)*CW +: CW] <= r_run[int'(r_idx)*CW +: CW];
            r_count <= r_count + c_one;
          end else begin
            r_pop[(int'(r_cnt) - 1 - int'(r_idx))*CW +: CW] <= w_top;
            r_pile[(int'(r_count) - 1)*CW +: CW] <= '0;
            r_count <= r_count - c_one;
          end
        end
        S_REVEAL: begin
          r_pile[(int'(r_count) - 1)*CW] <= 1'b1;
          r_rev <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pop_cards    = r_pop;
  assign o_done         = r_done;
  assign o_ok           = r_ok;
  assign o_revealed     = r_rev;
  assign o_pile         = r_pile;
  assign o_count        = r_count;
  assign o_top_card     = w_top;
  assign o_hidden_count = w_hidden;

endmodule
`default_nettype wire

// File: tb/tb_card_pile_engine.sv
`default_nettype none
// Bench for card_pile_engine: tableau (inst 0) and foundation (inst 1) piles
// against a queue-free array model of the solitaire pile rules.
module tb_card_pile_engine;
  localparam int DEPTH = 19, MAX_RUN = 13, CW = 7, NW = 5;

  typedef logic [CW-1:0] run_t [MAX_RUN];
  typedef logic [CW-1:0] lp_t  [DEPTH];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  load_v [2];
  logic                  op_v   [2];
  logic [DEPTH*CW-1:0]   load_pile;
  logic [NW-1:0]         load_count;
  logic [1:0]            op_code;
  logic [NW-1:0]         op_count;
  logic [MAX_RUN*CW-1:0] push_cards;
  logic                  ready [2], done [2], ok [2], rev [2];
  logic [MAX_RUN*CW-1:0] popc  [2];
  logic [DEPTH*CW-1:0]   pile  [2];
  logic [NW-1:0]         cnt   [2], hid [2];
  logic [CW-1:0]         top   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    card_pile_engine #(.DEPTH(DEPTH), .MAX_RUN(MAX_RUN), .MODE(g), .AUTO_REVEAL(1)) u_dut (
      .clk(clk), .rst(rst),
      .i_load_valid(load_v[g]), .i_load_pile(load_pile), .i_load_count(load_count),
      .i_op_valid(op_v[g]), .o_op_ready(ready[g]), .i_op_code(op_code),
      .i_op_count(op_count), .i_push_cards(push_cards), .o_pop_cards(popc[g]),
      .o_done(done[g]), .o_ok(ok[g]), .o_revealed(rev[g]), .o_pile(pile[g]),
      .o_count(cnt[g]), .o_top_card(top[g]), .o_hidden_count(hid[g]));
  end

  logic [CW-1:0]         mp   [2][DEPTH];
  int                    mc   [2];
  logic [MAX_RUN*CW-1:0] mpop [2];
  int checks = 0;
  int errors = 0;

  function automatic int rk(logic [CW-1:0] c); return int'(c[6:3]); endfunction
  function automatic bit is_red(logic [CW-1:0] c); return (c[2:1] == 2'b00) || (c[2:1] == 2'b10); endfunction
  function automatic logic [CW-1:0] mk(int r, logic [1:0] s, logic v); return {4'(r), s, v}; endfunction

  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; mpop[i] = '0;
      for (int k = 0; k < DEPTH; k++) mp[i][k] = '0;
    end
  endtask

  task automatic check_state(int i, string tag);
    logic [DEPTH*CW-1:0] ep;
    logic [CW-1:0] et;
    int eh;
    ep = '0; et = '0; eh = 0;
    for (int k = 0; k < mc[i]; k++) begin
      ep[k*CW +: CW] = mp[i][k];
      if (!mp[i][k][0]) eh++;
    end
    if (mc[i] > 0) et = mp[i][mc[i]-1];
    chk({tag, ".count"},  160'(cnt[i]), 160'(mc[i]));
    chk({tag, ".pile"},   160'(pile[i]), 160'(ep));
    chk({tag, ".top"},    160'(top[i]), 160'(et));
    chk({tag, ".hidden"}, 160'(hid[i]), 160'(eh));
    chk({tag, ".pop"},    160'(popc[i]), 160'(mpop[i]));
  endtask

  task automatic wait_done(int i, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done[i]) begin lat = k; break; end
    end
  endtask

  // Rules model: returns expected ok/revealed/latency and updates the pile.
  task automatic model_op(int i, logic [1:0] code, int n, run_t run,
                          output bit eok, output bit erev, output int lat);
    bit legal;
    int t;
    logic [CW-1:0] c, below;
    eok = 0; erev = 0; lat = 2; legal = 0; t = mc[i];
    if (code == 2'b01) begin
      legal = (n >= 1 && n <= MAX_RUN && t + n <= DEPTH);
      if (i == 1 && n != 1) legal = 0;
      if (legal) begin
        for (int k = 0; k < n; k++) begin
          c = run[k];
          if (k > 0) below = run[k-1];
          else if (t > 0) below = mp[i][t-1];
          else below = '0;
          if (!c[0] || rk(c) == 0) legal = 0;
          if (i == 0) begin
            if (k == 0 && t == 0) legal &= (rk(c) == 13);
            else legal &= (rk(c) == rk(below) - 1) && (is_red(c) != is_red(below));
          end else begin
            if (t == 0) legal &= (rk(c) == 1);
            else legal &= (c[2:1] == below[2:1]) && (rk(c) == rk(below) + 1);
          end
        end
      end
      if (legal) begin
        for (int k = 0; k < n; k++) mp[i][t+k] = run[k];
        mc[i] = t + n; lat = 2 + n; eok = 1;
      end
    end else if (code == 2'b10) begin
      legal = (n >= 1 && n <= MAX_RUN && n <= t);
      if (legal) for (int k = t - n; k < t; k++) if (!mp[i][k][0]) legal = 0;
      if (legal) begin
        mpop[i] = '0;
        for (int k = 0; k < n; k++) begin
          mpop[i][k*CW +: CW] = mp[i][t-n+k];
          mp[i][t-n+k] = '0;
        end
        mc[i] = t - n; lat = 2 + n; eok = 1;
        if (mc[i] > 0 && !mp[i][mc[i]-1][0]) begin
          mp[i][mc[i]-1][0] = 1'b1; erev = 1; lat++;
        end
      end
    end else if (code == 2'b11) begin
      if (t > 0 && !mp[i][t-1][0]) begin
        mp[i][t-1][0] = 1'b1; eok = 1; erev = 1; lat = 3;
      end
    end
  endtask

  task automatic do_op(int i, logic [1:0] code, int n, run_t run, string tag);
    bit eok, erev;
    int elat, lat;
    @(negedge clk);
    op_code = code;
    op_count = n[NW-1:0];
    for (int k = 0; k < MAX_RUN; k++) push_cards[k*CW +: CW] = run[k];
    chk({tag, ".ready"}, 160'(ready[i]), 160'(1));
    op_v[i] = 1'b1;
    @(posedge clk); #1;
    op_v[i] = 1'b0;
    model_op(i, code, n, run, eok, erev, elat);
    wait_done(i, lat);
    chk({tag, ".latency"}, 160'(lat), 160'(elat));
    chk({tag, ".ok"}, 160'(ok[i]), 160'(eok));
    chk({tag, ".revealed"}, 160'(rev[i]), 160'(erev));
    check_state(i, tag);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 160'(done[i]), 160'(0));
  endtask

  task automatic drive_load(int i, lp_t cards, int n);
    for (int k = 0; k < DEPTH; k++) load_pile[k*CW +: CW] = cards[k];
    load_count = n[NW-1:0];
    load_v[i] = 1'b1;
  endtask

  task automatic model_load(int i, lp_t cards, int n);
    if (n <= DEPTH) begin
      mc[i] = n;
      for (int k = 0; k < DEPTH; k++) mp[i][k] = (k < n) ? cards[k] : '0;
    end
  endtask

  task automatic do_load(int i, lp_t cards, int n, string tag);
    int lat;
    @(negedge clk);
    drive_load(i, cards, n);
    @(posedge clk); #1;
    load_v[i] = 1'b0;
    model_load(i, cards, n);
    wait_done(i, lat);
    chk({tag, ".latency"}, 160'(lat), 160'(1));
    chk({tag, ".ok"}, 160'(ok[i]), 160'(n <= DEPTH));
    chk({tag, ".revealed"}, 160'(rev[i]), 160'(0));
    check_state(i, tag);
  endtask

  initial begin
    run_t r;
    lp_t  lp;
    int   n, pr, extra, sel, inst;
    bit   pred;
    logic [CW-1:0] tc;
    for (int i = 0; i < 2; i++) begin load_v[i] = 0; op_v[i] = 0; end
    load_pile = '0; load_count = '0; op_code = '0; op_count = '0; push_cards = '0;
    r  = '{default: '0};
    lp = '{default: '0};
    model_clear();
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_state(i, "reset");
      chk("reset.done", 160'(done[i]), 160'(0));
      chk("reset.ok", 160'(ok[i]), 160'(0));
      chk("reset.rev", 160'(rev[i]), 160'(0));
      chk("reset.ready", 160'(ready[i]), 160'(1));
    end

    // Tableau: Q on empty rejected, K accepted, then QH JC run, then 2H rejected.
    r[0] = 7'h61; do_op(0, 2'b01, 1, r, "t1_qh_empty");
    r[0] = 7'h6F; do_op(0, 2'b01, 1, r, "t1_ks_empty");
    chk("t1_top", 160'(top[0]), 160'(7'h6F));
    r[0] = 7'h61; r[1] = 7'h5B; do_op(0, 2'b01, 2, r, "t2_run2");
    chk("t2_top", 160'(top[0]), 160'(7'h5B));
    r[0] = 7'h11; do_op(0, 2'b01, 1, r, "t2_bad");
    r = '{default: '0};
    do_op(0, 2'b01, 14, r, "run_too_long");

    // Pop with auto-reveal of the hidden 5C beneath.
    lp = '{default: '0}; lp[0] = 7'h2A; lp[1] = 7'h11; lp[5] = 7'h7F;
    do_load(0, lp, 2, "t3_load");
    do_op(0, 2'b10, 1, r, "t3_pop");
    chk("t3_pop0", 160'(popc[0][CW-1:0]), 160'(7'h11));
    chk("t3_top", 160'(top[0]), 160'(7'h2B));

    // Foundation.
    r[0] = 7'h09; do_op(1, 2'b01, 1, r, "t4_ah");
    r[0] = 7'h11; do_op(1, 2'b01, 1, r, "t4_2h");
    r[0] = 7'h13; do_op(1, 2'b01, 1, r, "t4_2c");
    r[0] = 7'h19; r[1] = 7'h21; do_op(1, 2'b01, 2, r, "t4_two");

    // Illegal ops.
    lp = '{default: '0}; lp[0] = 7'h2A; lp[1] = 7'h11;
    do_load(0, lp, 2, "t5_load");
    do_op(0, 2'b10, 3, r, "t5_pop3");
    do_op(0, 2'b10, 0, r, "t5_pop0");
    do_op(0, 2'b00, 1, r, "t5_code0");
    lp[1] = 7'h60; do_load(0, lp, 2, "t5_load_hid");
    do_op(0, 2'b10, 1, r, "t5_pop_hidden");
    do_op(0, 2'b11, 1, r, "t5_flip_ok");
    do_load(0, lp, 20, "t5_load_big");
    do_load(0, lp, 0, "t5_load_empty");
    do_op(0, 2'b11, 1, r, "t5_flip_empty");

    // Load wins over a simultaneous op request.
    lp = '{default: '0}; lp[0] = 7'h6F; lp[1] = 7'h61;
    @(negedge clk);
    drive_load(0, lp, 2);
    op_code = 2'b10; op_count = 5'd1; op_v[0] = 1'b1;
    @(posedge clk); #1;
    load_v[0] = 1'b0; op_v[0] = 1'b0;
    model_load(0, lp, 2);
    wait_done(0, n);
    chk("t6_load_lat", 160'(n), 160'(1));
    chk("t6_load_ok", 160'(ok[0]), 160'(1));
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (done[0]) extra++; end
    chk("t6_no_op", 160'(extra), 160'(0));
    check_state(0, "t6_after");

    // Reset in the middle of a 3-card push abandons it without done.
    lp = '{default: '0}; lp[0] = 7'h6F;
    do_load(0, lp, 1, "t6_reload");
    @(negedge clk);
    op_code = 2'b01; op_count = 5'd3;
    push_cards = '0;
    push_cards[0 +: CW] = 7'h61; push_cards[CW +: CW] = 7'h5B; push_cards[2*CW +: CW] = 7'h51;
    op_v[0] = 1'b1;
    @(posedge clk); #1; op_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
    chk("t6_rst_count", 160'(cnt[0]), 160'(0));
    chk("t6_rst_done", 160'(done[0]), 160'(0));
    @(negedge clk); rst = 1'b1;
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (done[0] || done[1]) extra++; end
    chk("t6_rst_nodone", 160'(extra), 160'(0));
    check_state(0, "t6_rst0");
    check_state(1, "t6_rst1");

    // Randomized traffic on both piles.
    for (int it = 0; it < 200; it++) begin
      inst = $urandom_range(0, 1);
      sel  = $urandom_range(0, 9);
      r    = '{default: '0};
      if (sel == 0) begin
        n = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 25) : $urandom_range(0, DEPTH);
        for (int k = 0; k < DEPTH; k++)
          lp[k] = mk($urandom_range(1, 13), 2'($urandom_range(0, 3)),
                     (k >= n - 3) ? 1'b1 : 1'($urandom_range(0, 1)));
        do_load(inst, lp, n, "rnd_load");
      end else if (sel <= 4) begin
        if (inst == 0) begin
          n = $urandom_range(1, 3);
          if (mc[0] > 0) begin pr = rk(mp[0][mc[0]-1]); pred = is_red(mp[0][mc[0]-1]); end
          else begin pr = 14; pred = 1'($urandom_range(0, 1)); end
          for (int k = 0; k < n; k++) begin
            pr--; pred = !pred;
            r[k] = mk(pr, pred ? {1'($urandom_range(0, 1)), 1'b0} : {1'($urandom_range(0, 1)), 1'b1}, 1'b1);
          end
        end else begin
          n = ($urandom_range(0, 7) == 0) ? 2 : 1;
          if (mc[1] > 0) begin tc = mp[1][mc[1]-1]; r[0] = mk(rk(tc) + 1, tc[2:1], 1'b1); end
          else r[0] = mk(1, 2'($urandom_range(0, 3)), 1'b1);
          r[1] = 7'($urandom);
        end
        if ($urandom_range(0, 3) == 0) r[$urandom_range(0, n - 1)] = 7'($urandom);
        do_op(inst, 2'b01, n, r, "rnd_push");
      end else if (sel <= 7) begin
        do_op(inst, 2'b10, $urandom_range(0, 4), r, "rnd_pop");
      end else if (sel == 8) begin
        do_op(inst, 2'b11, $urandom_range(0, 3), r, "rnd_flip");
      end else begin
        do_op(inst, 2'b00, $urandom_range(1, 3), r, "rnd_code0");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
